// File: rtl/inv_norm.sv
// ---------------------------------------------------------------------------
// inv_norm
//
// Input normalizer for the Newton-Raphson reciprocal datapath. It takes an
// unsigned operand and moves its leading one to bit 14. Bit 15 of the result
// is always clear, so the reciprocal stage's ROM address bits [13:8] always
// hold the six bits that follow the leading one. The block also reports the
// signed left shift it applied, so the result can be denormalized later.
//
// The block is a two-stage pipeline with valid/ready flow control. It also
// keeps a saturating count of the zero operands delivered to the output stage.
//
// Ports:
//   clk        single clock; all state changes on its rising edge
//   rst_n      asynchronous, active-low reset
//   x_in       unsigned operand (IPWRDLEN bits)
//   in_valid   x_in is valid this cycle
//   in_ready   block accepts x_in this cycle
//   x_norm     normalized operand: leading one at bit 14, bit 15 always 0
//   x_sh       signed two's-complement left shift applied, range -1..14
//   x_zero     operand was zero
//   out_valid  x_norm, x_sh and x_zero are valid
//   out_ready  downstream consumes the output this cycle
//   zero_clr   synchronous clear of zero_cnt (wins over increment)
//   zero_cnt   saturating count of zero operands delivered
// ---------------------------------------------------------------------------
module inv_norm #(
    parameter int IPWRDLEN  = 16,
    parameter int SHWIDTH   = 5,
    parameter int ZCNTWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IPWRDLEN-1:0]  x_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [IPWRDLEN-1:0]  x_norm,
    output logic [SHWIDTH-1:0]   x_sh,
    output logic                 x_zero,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 zero_clr,
    output logic [ZCNTWIDTH-1:0] zero_cnt
);

    localparam int MSBW = $clog2(IPWRDLEN);
    localparam logic [ZCNTWIDTH-1:0] ZERO_MAX = '1;

    logic                adv;
    logic                s1_v;
    logic [IPWRDLEN-1:0] s1_x;
    logic [MSBW-1:0]     msb;
    logic [MSBW-1:0]     lshift;
    logic                s1_zero;
    logic [IPWRDLEN-1:0] norm_val;
    logic [SHWIDTH-1:0]  sh_val;

    // The whole pipeline moves as one unit. It advances whenever the output
    // stage is empty or is being consumed. This makes in_ready a
    // combinational function of out_ready. In exchange, no skid buffer is
    // needed.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Stage 1 captures the raw operand. The data register only loads when the
    // operand is valid. During a bubble, the last operand stays put, which
    // keeps the data path quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1_x <= '0;
        end else if (adv) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_x <= x_in;
            end
        end
    end

    // Leading-one detect. The loop runs from bit 0 upward, so the highest set
    // bit is the last one to win. A zero operand leaves msb at 0. The zero
    // case is handled separately, so that value is never used.
    always_comb begin
        msb = '0;
        for (int i = 0; i < IPWRDLEN; i++) begin
            if (s1_x[i]) begin
                msb = i[MSBW-1:0];
            end
        end
    end

    // Normalization. An operand with the top bit set is the only one that
    // has to move right. It loses its LSB and reports a shift of -1. Every
    // other nonzero operand moves left until its leading one reaches bit 14.
    always_comb begin
        s1_zero  = (s1_x == '0);
        lshift   = MSBW'(IPWRDLEN - 2) - msb;
        norm_val = '0;
        sh_val   = '0;
        if (s1_zero) begin
            norm_val = '0;
            sh_val   = '0;
        end else if (s1_x[IPWRDLEN-1]) begin
            norm_val = s1_x >> 1;
            sh_val   = '1;
        end else begin
            norm_val = s1_x << lshift;
            sh_val   = SHWIDTH'(lshift);
        end
    end

    // Stage 2 is the output register set. When a bubble passes through, only
    // out_valid drops. The data fields keep the last delivered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            x_norm    <= '0;
            x_sh      <= '0;
            x_zero    <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_v;
            if (s1_v) begin
                x_norm <= norm_val;
                x_sh   <= sh_val;
                x_zero <= s1_zero;
            end
        end
    end

    // The zero-operand counter counts when a zero operand enters the output
    // stage. It does not wait for that operand to be consumed. A clear in the
    // same cycle wins, so a clear that coincides with a zero load leaves the
    // count at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt <= '0;
        end else if (zero_clr) begin
            zero_cnt <= '0;
        end else if (adv && s1_v && s1_zero && (zero_cnt != ZERO_MAX)) begin
            zero_cnt <= zero_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_inv_norm.sv
// ---------------------------------------------------------------------------
// tb_inv_norm
//
// Self-checking bench for inv_norm. It runs directed sequences first: reset,
// basic shifts, top-bit operands, zero saturation, backpressure and reset in
// mid-stream. It then streams random operands with random in_valid and
// out_ready against an arithmetic reference model and an in-order queue.
// ---------------------------------------------------------------------------
module tb_inv_norm;

    logic        clk;
    logic        rst_n;
    logic [15:0] x_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_norm;
    logic [4:0]  x_sh;
    logic        x_zero;
    logic        out_valid;
    logic        out_ready;
    logic        zero_clr;
    logic [7:0]  zero_cnt;

    int tests;
    int failed;

    inv_norm #(
        .IPWRDLEN  (16),
        .SHWIDTH   (5),
        .ZCNTWIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_in      (x_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_norm    (x_norm),
        .x_sh      (x_sh),
        .x_zero    (x_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .zero_clr  (zero_clr),
        .zero_cnt  (zero_cnt)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model. It doubles the operand until it reaches 0x4000,
    // counting the doublings. An operand that is already at or above 0x8000
    // is halved instead and reports a shift of -1.
    function automatic logic [21:0] refNorm(input logic [15:0] x);
        int v;
        int sh;
        logic [15:0] n;
        logic [4:0]  s;
        logic        z;
        v  = int'(x);
        sh = 0;
        if (v == 0) begin
            n = 16'h0000;
            s = 5'd0;
            z = 1'b1;
        end else if (v >= 32768) begin
            n = 16'(v / 2);
            s = 5'h1F;
            z = 1'b0;
        end else begin
            while (v < 16384) begin
                v  = v * 2;
                sh = sh + 1;
            end
            n = 16'(v);
            s = 5'(sh);
            z = 1'b0;
        end
        return {n, s, z};
    endfunction

    // Waits for the next rising edge, then steps just past it so that DUT
    // outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] x, input logic rdy);
        in_valid  = v;
        x_in      = x;
        out_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Basic-shift table: operands streamed back to back, with the expected
    // {out_valid, x_norm, x_sh, x_zero} for each.
    logic [15:0] basic_x   [6];
    logic [22:0] basic_exp [6];

    // Scoreboard state for the random phase.
    logic [15:0] pending [$];
    logic [15:0] held_norm;
    logic [4:0]  held_sh;
    logic        held_zero;
    logic        was_stalled;
    logic [15:0] rx;
    logic [15:0] px;
    logic [21:0] e;
    int          accepted;
    int          cycles;
    int          zeros;
    int          r;

    initial begin
        tests    = 0;
        failed   = 0;
        rst_n    = 1'b0;
        zero_clr = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0);

        basic_x[0] = 16'h0001; basic_exp[0] = {1'b1, 16'h4000, 5'd14,  1'b0};
        basic_x[1] = 16'h0123; basic_exp[1] = {1'b1, 16'h48C0, 5'd6,   1'b0};
        basic_x[2] = 16'h4ABC; basic_exp[2] = {1'b1, 16'h4ABC, 5'd0,   1'b0};
        basic_x[3] = 16'h8000; basic_exp[3] = {1'b1, 16'h4000, 5'h1F,  1'b0};
        basic_x[4] = 16'hFFFF; basic_exp[4] = {1'b1, 16'h7FFF, 5'h1F,  1'b0};
        basic_x[5] = 16'h0000; basic_exp[5] = {1'b1, 16'h0000, 5'd0,   1'b1};

        // Reset state, observed while reset is still asserted.
        #12;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_outputs", 32'({x_norm, x_sh, x_zero}), 32'd0);
        checkOutput("reset_zero_cnt", 32'(zero_cnt), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Basic shifts, top-bit and zero operands streamed back to back.
        // Each result is visible two edges after its operand is accepted.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, basic_x[i], 1'b1);
            tick();
            if (i == 0) begin
                checkOutput("basic_latency", 32'(out_valid), 32'd0);
            end else begin
                checkOutput($sformatf("basic_%0d", i - 1),
                            32'({out_valid, x_norm, x_sh, x_zero}), 32'(basic_exp[i - 1]));
            end
        end
        applyStimulus(1'b0, 16'h0000, 1'b1);
        tick();
        checkOutput("basic_5", 32'({out_valid, x_norm, x_sh, x_zero}), 32'(basic_exp[5]));
        checkOutput("zero_cnt_one", 32'(zero_cnt), 32'd1);
        tick();
        checkOutput("basic_drained", 32'(out_valid), 32'd0);

        // 300 more zeros push the counter to saturation.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 16'h0000, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 16'h0000, 1'b1);
        tick();
        tick();
        checkOutput("zero_cnt_saturated", 32'(zero_cnt), 32'd255);
        zero_clr = 1'b1;
        tick();
        zero_clr = 1'b0;
        checkOutput("zero_cnt_cleared", 32'(zero_cnt), 32'd0);

        // A clear in the same cycle as a zero load leaves the count at 0.
        applyStimulus(1'b1, 16'h0000, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        zero_clr = 1'b1;
        tick();
        zero_clr = 1'b0;
        checkOutput("clr_with_zero_load_out", 32'({out_valid, x_zero}), 32'b11);
        checkOutput("clr_with_zero_load_cnt", 32'(zero_cnt), 32'd0);
        tick();

        // Backpressure: hold out_ready low for 3 cycles after the first output.
        applyStimulus(1'b1, 16'h0001, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h0002, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h0003, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("stall_in_ready_%0d", i), 32'(in_ready), 32'd0);
            checkOutput($sformatf("stall_hold_%0d", i),
                        32'({out_valid, x_norm, x_sh}), 32'({1'b1, 16'h4000, 5'd14}));
            tick();
        end
        applyStimulus(1'b1, 16'h0003, 1'b1);
        #1;
        checkOutput("stall_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("stall_out_2", 32'({out_valid, x_norm, x_sh}), 32'({1'b1, 16'h4000, 5'd13}));
        tick();
        checkOutput("stall_out_3", 32'({out_valid, x_norm, x_sh}), 32'({1'b1, 16'h6000, 5'd13}));
        tick();
        checkOutput("stall_no_repeat", 32'(out_valid), 32'd0);

        // Reset in mid-stream with two operands in flight and a nonzero count.
        applyStimulus(1'b1, 16'h0000, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h0005, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h0007, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("midrst_count_before", 32'(zero_cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_zero_cnt", 32'(zero_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h0010, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("midrst_discarded", 32'(out_valid), 32'd0);
        tick();
        checkOutput("midrst_after", 32'({out_valid, x_norm, x_sh, x_zero}),
                    32'({1'b1, 16'h4000, 5'd10, 1'b0}));
        tick();

        // Random streaming against the reference model.
        zero_clr = 1'b1;
        tick();
        zero_clr    = 1'b0;
        accepted    = 0;
        cycles      = 0;
        zeros       = 0;
        was_stalled = 1'b0;
        held_norm   = '0;
        held_sh     = '0;
        held_zero   = 1'b0;
        while (accepted < 10000 && cycles < 40000) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                rx = 16'h0000;
            end else if (r == 1) begin
                rx = 16'h8000 | 16'($urandom);
            end else if (r == 2) begin
                rx = 16'h0001 << $urandom_range(0, 15);
            end else begin
                rx = 16'($urandom) >> $urandom_range(0, 15);
            end
            applyStimulus($urandom_range(0, 3) != 0, rx, $urandom_range(0, 3) != 0);
            #1;
            if (was_stalled) begin
                checkOutput("rand_stall_stable", 32'({out_valid, x_norm, x_sh, x_zero}),
                            32'({1'b1, held_norm, held_sh, held_zero}));
            end
            if (out_valid && out_ready) begin
                if (pending.size() == 0) begin
                    checkOutput("rand_unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    px = pending.pop_front();
                    e  = refNorm(px);
                    checkOutput($sformatf("rand_x_%04h", px), 32'({x_norm, x_sh, x_zero}), 32'(e));
                    if (px != 16'h0000) begin
                        checkOutput($sformatf("rand_top_bits_%04h", px),
                                    32'(x_norm[15:14]), 32'b01);
                    end
                end
            end
            was_stalled = out_valid && !out_ready;
            held_norm   = x_norm;
            held_sh     = x_sh;
            held_zero   = x_zero;
            if (in_valid && in_ready) begin
                pending.push_back(x_in);
                accepted++;
                if (x_in == 16'h0000) begin
                    zeros++;
                end
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("rand_all_accepted", 32'(accepted), 32'd10000);

        // Drain the pipeline and settle the scoreboard and zero counter.
        applyStimulus(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (out_valid && pending.size() != 0) begin
                px = pending.pop_front();
                e  = refNorm(px);
                checkOutput($sformatf("drain_x_%04h", px), 32'({x_norm, x_sh, x_zero}), 32'(e));
            end
            tick();
        end
        checkOutput("rand_queue_empty", 32'(pending.size()), 32'd0);
        checkOutput("rand_zero_cnt", 32'(zero_cnt), 32'((zeros > 255) ? 255 : zeros));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/inv_norm.md
# inv_norm

Input normalizer for the Newton-Raphson reciprocal datapath. Accepts a 16-bit unsigned operand, moves its leading one to bit 14 (Q1.15 form with bit 15 clear) so the reciprocal stage's ROM address bits [13:8] always hold the six bits after the leading one, and reports the signed shift used for later denormalization. The block is a two-stage pipeline with valid/ready flow control and a saturating zero-operand counter. It sits directly upstream of the reciprocal stage.

## Interface
- IPWRDLEN, 16, operand width; this revision supports only 16.
- SHWIDTH, 5, width of the signed shift-count output.
- ZCNTWIDTH, 8, width of the zero-operand counter.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- x_in  input  IPWRDLEN  unsigned operand.
- in_valid  input  1  x_in is valid this cycle.
- in_ready  output  1  block accepts x_in this cycle.
- x_norm  output  IPWRDLEN  normalized operand; leading one at bit 14, bit 15 always 0.
- x_sh  output  SHWIDTH  signed two's-complement left-shift applied, range -1..14.
- x_zero  output  1  operand was zero.
- out_valid  output  1  x_norm, x_sh and x_zero are valid.
- out_ready  input  1  downstream consumes the output this cycle.
- zero_clr  input  1  synchronous clear of zero_cnt.
- zero_cnt  output  ZCNTWIDTH  saturating count of zero operands delivered.

## Operation
- Global advance: adv = ~out_valid | out_ready. in_ready = adv. This is a combinational path from out_ready and state.
- Stage 1, loaded when adv:
  - s1_v <= in_valid.
  - s1_x <= x_in when in_valid; otherwise s1_x holds.
- Leading-one detect on s1_x gives msb, the highest set bit index.
- Shift and output rules:
  - msb = 15: x_norm = s1_x >> 1 with the LSB truncated, x_sh = -1 (5'h1F).
  - msb 0..14: x_norm = s1_x << (14 - msb), x_sh = 14 - msb.
  - s1_x = 0: x_norm = 0, x_sh = 0, x_zero = 1.
  - Otherwise x_zero = 0.
- Stage 2 (the output registers), loaded when adv:
  - out_valid <= s1_v.
  - x_norm, x_sh and x_zero load from the stage-1 computation when s1_v; otherwise they hold.
- While adv = 0, both stages and all outputs hold unchanged.
- zero_cnt update:
  - zero_clr = 1: zero_cnt <= 0. This has priority over increment.
  - Else, on a stage-2 load with s1_v = 1 and s1_x = 0: zero_cnt increments, saturating at 2^ZCNTWIDTH-1 (255).
- No state machine beyond the pipeline valid bits.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - s1_v = 0, s1_x = 0.
  - out_valid = 0, x_norm = 0, x_sh = 0, x_zero = 0.
  - zero_cnt = 0.
- in_ready is 1 during and immediately after reset, because out_valid = 0.
- Latency: an operand accepted at edge N (in_valid & in_ready) appears with out_valid = 1 after edge N+1, provided adv was 1 at edge N+1.
- Throughput: one operand per clock while out_ready = 1.
- Stall: out_valid = 1 and out_ready = 0 forces in_ready = 0. Outputs stay stable until the cycle out_ready = 1. No data is lost or duplicated.
- Bubbles: a bubble in stage 1 (s1_v = 0) propagates as out_valid = 0. Bubbles are not collapsed during a stall.
- Reset mid-stream: all in-flight operands are discarded. The first operand accepted after rst_n rises follows normal latency.
- zero_clr coinciding with a zero-operand load: the count ends at 0.

## Test plan
- Basic shifts with out_ready = 1:
  - x_in 0x0001 -> x_norm 0x4000, x_sh 14.
  - 0x0123 -> 0x48C0, x_sh 6.
  - 0x4ABC -> 0x4ABC, x_sh 0.
  - Each output appears two edges after acceptance.
- Top-bit operands:
  - 0x8000 -> 0x4000, x_sh 5'h1F.
  - 0xFFFF -> 0x7FFF, x_sh 5'h1F.
- Zero operand: x_in 0x0000 -> x_norm 0, x_sh 0, x_zero 1, zero_cnt 1. Send 300 zeros -> zero_cnt 255 (saturated). Pulse zero_clr -> zero_cnt 0.
- Backpressure:
  - Stream 0x0001, 0x0002, 0x0003 with out_ready low for 3 cycles after the first output.
  - Required: in_ready low throughout, x_norm held at 0x4000.
  - After out_ready rises: outputs 0x4000, 0x4000, 0x6000 with x_sh 14, 13, 13, in order, no repeats.
- Reset mid-operation: assert rst_n low with two operands in flight -> out_valid 0 and zero_cnt 0 immediately (asynchronous). After release, 0x0010 -> 0x4000, x_sh 10.
- Random: 10k random operands with random in_valid/out_ready. Compare against a reference model for x_norm, x_sh and x_zero. Check x_norm[15] = 0 and x_norm[14] = 1 for every nonzero operand.
